// File: rtl/conv_idx_pkg.sv
// Shared types for the conv loop-nest index generator: index widths, tuple
// struct, FSM state encoding, compare codes and the odometer step function.
package conv_idx_pkg;

  localparam int unsigned IDX_W_H   = 3;
  localparam int unsigned IDX_W_W   = 3;
  localparam int unsigned IDX_W_R   = 3;
  localparam int unsigned IDX_W_S   = 3;
  localparam int unsigned IDX_W_K   = 3;
  localparam int unsigned COMP_W    = 2;
  localparam int unsigned STAT_W    = 16;
  localparam int unsigned VLD_W     = 3;
  localparam int unsigned REM_W_MIN = 10;

  typedef struct packed {
    logic [IDX_W_H-1:0] h;
    logic [IDX_W_W-1:0] w;
    logic [IDX_W_R-1:0] r;
    logic [IDX_W_S-1:0] s;
    logic [IDX_W_K-1:0] k;
  } idx_tuple_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [COMP_W-1:0] COMP_ALL  = 2'd0;
  localparam logic [COMP_W-1:0] COMP_AB   = 2'd1;
  localparam logic [COMP_W-1:0] COMP_BC   = 2'd2;
  localparam logic [COMP_W-1:0] COMP_NONE = 2'd3;

  // One odometer step: s innermost, k outermost; lim holds DIM-1 per field.
  function automatic idx_tuple_t next_tuple(input idx_tuple_t t, input idx_tuple_t lim);
    idx_tuple_t n;
    n = t;
    if (t.s != lim.s) n.s = t.s + IDX_W_S'(1);
    else begin
      n.s = '0;
      if (t.r != lim.r) n.r = t.r + IDX_W_R'(1);
      else begin
        n.r = '0;
        if (t.w != lim.w) n.w = t.w + IDX_W_W'(1);
        else begin
          n.w = '0;
          if (t.h != lim.h) n.h = t.h + IDX_W_H'(1);
          else begin
            n.h = '0;
            n.k = (t.k != lim.k) ? t.k + IDX_W_K'(1) : '0;
          end
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/conv_index_gen_if.sv
// Tuple-issue handshake between conv_index_gen (master) and AddrProcess (slave).
interface conv_index_gen_if;
  import conv_idx_pkg::*;

  logic                start;
  idx_tuple_t          a;
  idx_tuple_t          b;
  idx_tuple_t          c;
  logic [VLD_W-1:0]    vld;
  logic                finish;
  logic [COMP_W-1:0]   comp;

  modport master (output start, a, b, c, vld, input finish, comp);
  modport slave  (input start, a, b, c, vld, output finish, comp);
endinterface

// File: rtl/conv_idx_odometer.sv
// Holds the A/B/C tuples, the remaining-tuple count and the slot-valid mask.
// Supports load-zero and step-by-3; slots past the end repeat the last tuple.
module conv_idx_odometer
  import conv_idx_pkg::*;
#(
  parameter int unsigned K_DIM = 2,
  parameter int unsigned H_DIM = 4,
  parameter int unsigned W_DIM = 4,
  parameter int unsigned R_DIM = 3,
  parameter int unsigned S_DIM = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  output idx_tuple_t       o_a,
  output idx_tuple_t       o_b,
  output idx_tuple_t       o_c,
  output logic [VLD_W-1:0] o_vld,
  output logic             o_more_c
);

  localparam int unsigned N     = K_DIM * H_DIM * W_DIM * R_DIM * S_DIM;
  localparam int unsigned REM_W = ($clog2(N + 1) > REM_W_MIN) ? $clog2(N + 1) : REM_W_MIN;
  localparam idx_tuple_t  LIM   = '{h: IDX_W_H'(H_DIM - 1), w: IDX_W_W'(W_DIM - 1),
                                    r: IDX_W_R'(R_DIM - 1), s: IDX_W_S'(S_DIM - 1),
                                    k: IDX_W_K'(K_DIM - 1)};

  logic [REM_W-1:0] rem_q, rem_nxt;
  idx_tuple_t       a_nxt, b_nxt, c_nxt;
  logic [VLD_W-1:0] vld_nxt;

  // Next slot contents: rem counts tuples from slot A to the end of the layer.
  always_comb begin
    rem_nxt = rem_q;
    a_nxt   = o_a;
    b_nxt   = o_b;
    c_nxt   = o_c;
    vld_nxt = o_vld;
    if (i_load || i_step) begin
      rem_nxt = i_load ? REM_W'(N) : rem_q - REM_W'(3);
      a_nxt   = i_load ? '0 : next_tuple(o_c, LIM);
      b_nxt   = (rem_nxt >= REM_W'(2)) ? next_tuple(a_nxt, LIM) : a_nxt;
      c_nxt   = (rem_nxt >= REM_W'(3)) ? next_tuple(b_nxt, LIM) : b_nxt;
      vld_nxt = {rem_nxt >= REM_W'(3), rem_nxt >= REM_W'(2), rem_nxt >= REM_W'(1)};
    end
  end

  // Slot registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_q <= '0;
      o_a   <= '0;
      o_b   <= '0;
      o_c   <= '0;
      o_vld <= '0;
    end else begin
      rem_q <= rem_nxt;
      o_a   <= a_nxt;
      o_b   <= b_nxt;
      o_c   <= c_nxt;
      o_vld <= vld_nxt;
    end
  end

  assign o_more_c = rem_q > REM_W'(3);

endmodule

// File: rtl/conv_index_gen.sv
// Walks the conv loop nest (k,h,w,r,s) and issues index tuples to AddrProcess
// in groups of three, one start/finish handshake per group.
// Optional: define COMP_STATS_EN for saturating compare-code counters.
module conv_index_gen
  import conv_idx_pkg::*;
#(
  parameter int unsigned K_DIM = 2,
  parameter int unsigned H_DIM = 4,
  parameter int unsigned W_DIM = 4,
  parameter int unsigned R_DIM = 3,
  parameter int unsigned S_DIM = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic [COMP_W-1:0]   o_last_comp,
  output logic [STAT_W-1:0]   o_cnt_all,
  output logic [STAT_W-1:0]   o_cnt_ab,
  output logic [STAT_W-1:0]   o_cnt_bc,
  output logic [STAT_W-1:0]   o_cnt_none,
  conv_index_gen_if.master    bus
);

  state_t state_q, state_nxt;
  logic   load, step, acc_fin, more;

  conv_idx_odometer #(
    .K_DIM(K_DIM), .H_DIM(H_DIM), .W_DIM(W_DIM), .R_DIM(R_DIM), .S_DIM(S_DIM)
  ) u_odo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (load),
    .i_step   (step),
    .o_a      (bus.a),
    .o_b      (bus.b),
    .o_c      (bus.c),
    .o_vld    (bus.vld),
    .o_more_c (more)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  // Next-state and odometer control; finish only counts in WAIT.
  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    step      = 1'b0;
    acc_fin   = 1'b0;
    case (state_q)
      IDLE:  if (i_start) begin
               load      = 1'b1;
               state_nxt = ISSUE;
             end
      ISSUE: state_nxt = WAIT;
      WAIT:  if (bus.finish) begin
               acc_fin   = 1'b1;
               step      = more;
               state_nxt = more ? ISSUE : DONE;
             end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Busy and last compare code.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_busy      <= 1'b0;
      o_last_comp <= COMP_NONE;
    end else begin
      o_busy <= (state_nxt == ISSUE) || (state_nxt == WAIT);
      if (acc_fin) o_last_comp <= bus.comp;
    end
  end

  assign bus.start = (state_q == ISSUE);
  assign o_done    = (state_q == DONE);

`ifdef COMP_STATS_EN
  logic [STAT_W-1:0] cnt_q [4];

  // Compare-code statistics over full groups, cleared on each new layer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (acc_fin && (bus.vld == 3'b111) && (cnt_q[bus.comp] != {STAT_W{1'b1}})) begin
      cnt_q[bus.comp] <= cnt_q[bus.comp] + STAT_W'(1);
    end
  end

  assign o_cnt_all  = cnt_q[COMP_ALL];
  assign o_cnt_ab   = cnt_q[COMP_AB];
  assign o_cnt_bc   = cnt_q[COMP_BC];
  assign o_cnt_none = cnt_q[COMP_NONE];
`else
  assign o_cnt_all  = '0;
  assign o_cnt_ab   = '0;
  assign o_cnt_bc   = '0;
  assign o_cnt_none = '0;
`endif

endmodule

// File: tb/tb_conv_index_gen.sv
// Self-checking bench for conv_index_gen: default layer on dut0, a short
// N=4 layer on dut1, AddrProcess behaviour driven by the bench.
module tb_conv_index_gen;
  import conv_idx_pkg::*;

`ifdef COMP_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic        busy0, done0, busy1, done1;
  logic [1:0]  lc0, lc1;
  logic [15:0] ca0, cab0, cbc0, cn0, ca1, cab1, cbc1, cn1;

  conv_index_gen_if bus0 ();
  conv_index_gen_if bus1 ();

  conv_index_gen dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .o_busy(busy0), .o_done(done0),
    .o_last_comp(lc0), .o_cnt_all(ca0), .o_cnt_ab(cab0), .o_cnt_bc(cbc0),
    .o_cnt_none(cn0), .bus(bus0)
  );

  conv_index_gen #(.K_DIM(1), .H_DIM(1), .W_DIM(1), .R_DIM(2), .S_DIM(2)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .o_busy(busy1), .o_done(done1),
    .o_last_comp(lc1), .o_cnt_all(ca1), .o_cnt_ab(cab1), .o_cnt_bc(cbc1),
    .o_cnt_none(cn1), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;
  int n_start0 = 0, n_done0 = 0;

  // Pulse counters for the default-size instance.
  always @(posedge clk) begin
    if (bus0.start === 1'b1) n_start0 <= n_start0 + 1;
    if (done0 === 1'b1)      n_done0  <= n_done0 + 1;
  end

  // Reference tuple stream: plain nested loops in loop-nest order.
  idx_tuple_t ref_q[$];

  task automatic build_ref(input int kd, input int hd, input int wd, input int rd, input int sd);
    idx_tuple_t t;
    ref_q.delete();
    for (int k = 0; k < kd; k++)
      for (int h = 0; h < hd; h++)
        for (int w = 0; w < wd; w++)
          for (int r = 0; r < rd; r++)
            for (int s = 0; s < sd; s++) begin
              t.k = 3'(k); t.h = 3'(h); t.w = 3'(w); t.r = 3'(r); t.s = 3'(s);
              ref_q.push_back(t);
            end
  endtask

  function automatic idx_tuple_t exp_slot(input int idx);
    if (idx < ref_q.size()) return ref_q[idx];
    return ref_q[ref_q.size() - 1];
  endfunction

  function automatic logic [2:0] exp_vld(input int g);
    logic [2:0] v;
    for (int j = 0; j < 3; j++) v[j] = (3 * g + j) < ref_q.size();
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus0.start, busy0, done0, bus0.vld, bus0.a, bus0.b, bus0.c, lc0, ca0, cab0, cbc0, cn0} !==
        {1'b0, 1'b0, 1'b0, 3'b000, 45'd0, 2'd3, 64'd0}) begin
      errors++;
      $display("FAIL reset0 got start=%b busy=%b done=%b vld=%b a=%h lc=%0d exp 0/0/0/000/0/3",
               bus0.start, busy0, done0, bus0.vld, bus0.a, lc0);
    end
    checks++;
    if ({bus1.start, busy1, done1, bus1.vld, bus1.a, lc1} !== {6'd0, 15'd0, 2'd3}) begin
      errors++;
      $display("FAIL reset1 got start=%b busy=%b done=%b vld=%b a=%h lc=%0d exp 0/0/0/000/0/3",
               bus1.start, busy1, done1, bus1.vld, bus1.a, lc1);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Walk one layer on dut0 with an AddrProcess model; optional stall, poke or abort group.
  task automatic walk_layer(input int comp_mode, input int stall_grp, input int poke_grp,
                            input int abort_grp);
    int n_grp, s0, d0, t;
    int exp_cnt[4];
    logic [1:0] cmp;
    idx_tuple_t ea, eb, ec;
    logic [2:0] ev;
    n_grp = (ref_q.size() + 2) / 3;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    s0 = n_start0;
    d0 = n_done0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    checks++;
    if ({bus0.start, busy0, ca0, cab0, cbc0, cn0} !== {2'b11, 64'd0}) begin
      errors++;
      $display("FAIL accept got start=%b busy=%b cnt=%0d/%0d/%0d/%0d exp start=1 busy=1 cnt=0",
               bus0.start, busy0, ca0, cab0, cbc0, cn0);
    end
    for (int g = 0; g < n_grp; g++) begin
      t = 0;
      while (bus0.start !== 1'b1 && t < 8) begin
        @(negedge clk);
        t++;
      end
      if (bus0.start !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL start_timeout group=%0d got start=%b exp 1", g, bus0.start);
        return;
      end
      ea = exp_slot(3 * g); eb = exp_slot(3 * g + 1); ec = exp_slot(3 * g + 2); ev = exp_vld(g);
      checks++;
      if ({bus0.a, bus0.b, bus0.c, bus0.vld} !== {ea, eb, ec, ev}) begin
        errors++;
        $display("FAIL tuples group=%0d got a=%h b=%h c=%h vld=%b exp a=%h b=%h c=%h vld=%b",
                 g, bus0.a, bus0.b, bus0.c, bus0.vld, ea, eb, ec, ev);
      end
      cmp = (comp_mode == 1) ? 2'(g % 4) : 2'($urandom_range(0, 3));
      if (g == poke_grp) begin
        bus0.finish = 1'b1;
        bus0.comp = cmp;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if ({bus0.start, busy0, bus0.a, bus0.vld} !== {2'b01, ea, ev}) begin
          errors++;
          $display("FAIL ignore_in_issue group=%0d got start=%b busy=%b a=%h exp start=0 busy=1 a=%h",
                   g, bus0.start, busy0, bus0.a, ea);
        end
      end else begin
        @(negedge clk);
      end
      if (g == stall_grp) begin
        for (int i = 0; i < 20; i++) begin
          checks++;
          if ({bus0.start, busy0, done0, bus0.a, bus0.b, bus0.c, bus0.vld} !==
              {3'b010, ea, eb, ec, ev}) begin
            errors++;
            $display("FAIL stall cycle=%0d got start=%b busy=%b done=%b a=%h exp start=0 busy=1 done=0 a=%h",
                     i, bus0.start, busy0, done0, bus0.a, ea);
          end
          @(negedge clk);
        end
      end
      if (g == abort_grp) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus0.start, busy0, done0, bus0.vld, bus0.a, bus0.b, bus0.c, lc0, ca0, cab0, cbc0, cn0} !==
            {1'b0, 1'b0, 1'b0, 3'b000, 45'd0, 2'd3, 64'd0}) begin
          errors++;
          $display("FAIL abort got start=%b busy=%b done=%b vld=%b a=%h lc=%0d exp 0/0/0/000/0/3",
                   bus0.start, busy0, done0, bus0.vld, bus0.a, lc0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (n_done0 !== d0 || busy0 !== 1'b0) begin
          errors++;
          $display("FAIL abort_no_done got dones=%0d busy=%b exp dones=0 busy=0", n_done0 - d0, busy0);
        end
        return;
      end
      bus0.finish = 1'b1;
      bus0.comp = cmp;
      @(negedge clk);
      bus0.finish = 1'b0;
      if (ev == 3'b111) exp_cnt[cmp]++;
      checks++;
      if (lc0 !== cmp) begin
        errors++;
        $display("FAIL last_comp group=%0d got %0d exp %0d", g, lc0, cmp);
      end
      if (g == n_grp - 1) begin
        checks++;
        if ({done0, busy0, bus0.start} !== 3'b100) begin
          errors++;
          $display("FAIL done group=%0d got done=%b busy=%b start=%b exp 1/0/0", g, done0, busy0, bus0.start);
        end
        @(negedge clk);
        checks++;
        if ({done0, busy0} !== 2'b00) begin
          errors++;
          $display("FAIL done_pulse got done=%b busy=%b exp 0/0", done0, busy0);
        end
      end
    end
    checks++;
    if (n_start0 - s0 !== n_grp || n_done0 - d0 !== 1) begin
      errors++;
      $display("FAIL pulse_count got starts=%0d dones=%0d exp starts=%0d dones=1",
               n_start0 - s0, n_done0 - d0, n_grp);
    end
    if (!STATS_ON) for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    checks++;
    if ({ca0, cab0, cbc0, cn0} !== {16'(exp_cnt[0]), 16'(exp_cnt[1]), 16'(exp_cnt[2]), 16'(exp_cnt[3])}) begin
      errors++;
      $display("FAIL stats got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d", ca0, cab0, cbc0, cn0,
               exp_cnt[0], exp_cnt[1], exp_cnt[2], exp_cnt[3]);
    end
  endtask

  task automatic test_full_layer();
    build_ref(2, 4, 4, 3, 3);
    checks++;
    if (ref_q.size() !== 288) begin
      errors++;
      $display("FAIL ref_size got %0d exp 288", ref_q.size());
    end
    walk_layer(0, -1, -1, -1);
  endtask

  task automatic test_short_group();
    idx_tuple_t ea, eb, ec, last_t;
    int t;
    build_ref(1, 1, 1, 2, 2);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int g = 0; g < 2; g++) begin
      t = 0;
      while (bus1.start !== 1'b1 && t < 8) begin
        @(negedge clk);
        t++;
      end
      ea = exp_slot(3 * g); eb = exp_slot(3 * g + 1); ec = exp_slot(3 * g + 2);
      checks++;
      if ({bus1.start, bus1.a, bus1.b, bus1.c, bus1.vld} !== {1'b1, ea, eb, ec, exp_vld(g)}) begin
        errors++;
        $display("FAIL short group=%0d got start=%b a=%h b=%h c=%h vld=%b exp a=%h b=%h c=%h vld=%b",
                 g, bus1.start, bus1.a, bus1.b, bus1.c, bus1.vld, ea, eb, ec, exp_vld(g));
      end
      if (g == 1) begin
        last_t = '0;
        last_t.r = 3'd1;
        last_t.s = 3'd1;
        checks++;
        if ({bus1.a, bus1.b, bus1.c, bus1.vld} !== {last_t, last_t, last_t, 3'b001}) begin
          errors++;
          $display("FAIL short_last got a=%h b=%h c=%h vld=%b exp a=b=c=%h vld=001",
                   bus1.a, bus1.b, bus1.c, bus1.vld, last_t);
        end
      end
      @(negedge clk);
      bus1.finish = 1'b1;
      bus1.comp = 2'(g + 1);
      @(negedge clk);
      bus1.finish = 1'b0;
    end
    checks++;
    if ({done1, busy1, lc1} !== {2'b10, 2'd2}) begin
      errors++;
      $display("FAIL short_done got done=%b busy=%b lc=%0d exp done=1 busy=0 lc=2", done1, busy1, lc1);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    build_ref(2, 4, 4, 3, 3);
    walk_layer(0, 5, -1, -1);
  endtask

  task automatic test_ignore();
    build_ref(2, 4, 4, 3, 3);
    walk_layer(0, -1, 7, -1);
  endtask

  task automatic test_reset_abort();
    build_ref(2, 4, 4, 3, 3);
    walk_layer(0, -1, -1, 9);
    walk_layer(0, -1, -1, -1);
  endtask

  task automatic test_stats();
    build_ref(2, 4, 4, 3, 3);
    walk_layer(1, -1, -1, -1);
    checks++;
    if (STATS_ON ? ({ca0, cab0, cbc0, cn0} !== {4{16'd24}}) : ({ca0, cab0, cbc0, cn0} !== 64'd0)) begin
      errors++;
      $display("FAIL stats_cyclic got %0d/%0d/%0d/%0d exp %0d each", ca0, cab0, cbc0, cn0,
               STATS_ON ? 24 : 0);
    end
  endtask

  initial begin
    bus0.finish = 1'b0; bus0.comp = 2'd0;
    bus1.finish = 1'b0; bus1.comp = 2'd0;
    test_reset();
    test_full_layer();
    test_short_group();
    test_stall();
    test_ignore();
    test_reset_abort();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
